axi4_lite_master_adapter: RTL
=============================

AXI4_LITE_MASTER_ADAPTER -- requirements
Module: axi4_lite_master_adapter

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 12, address width of the request port and of AW/AR.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, data width; strobe width derived as AXI_DATA_WIDTH/8.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 aclk  in  1  sole clock, rising edge.
REQ-005 areset  in  1  asynchronous active-high reset.
REQ-006 req_valid  in  1  local request present.
REQ-007 req_ready  out  1  adapter idle, request accepted when req_valid&req_ready.
REQ-008 req_write  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  AXI_ADDR_WIDTH  target byte address.
REQ-010 req_wdata  in  AXI_DATA_WIDTH  write data.
REQ-011 req_wstrb  in  AXI_DATA_WIDTH/8  write byte strobes.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  AXI_DATA_WIDTH  read data of last completed read.
REQ-014 rsp_err  out  1  completion carried SLVERR/DECERR, valid with rsp_valid.
REQ-015 awaddr/awprot/awvalid  out  AXI_ADDR_WIDTH/3/1  AW channel; awready  in  1.
REQ-016 wdata/wstrb/wvalid  out  AXI_DATA_WIDTH/AXI_DATA_WIDTH/8/1  W channel; wready  in  1.
REQ-017 bresp  in  2, bvalid  in  1, bready  out  1  B channel.
REQ-018 araddr/arprot/arvalid  out  AXI_ADDR_WIDTH/3/1  AR channel; arready  in  1.
REQ-019 rdata  in  AXI_DATA_WIDTH, rresp  in  2, rvalid  in  1, rready  out  1  R channel.

Function
REQ-020 FSM states IDLE, WRITE, WR_RESP, READ, RD_RESP; req_ready = (state==IDLE); one transaction outstanding.
REQ-021 Accept: latch addr/wdata/wstrb; next state WRITE if req_write else READ.
REQ-022 WRITE: awvalid and wvalid both rise the cycle after accept; each drops after its own handshake; order free, same-cycle allowed; WR_RESP entered the cycle after both done.
REQ-023 WR_RESP: bready=1 only here; on bvalid: rsp_valid=1 next cycle, rsp_err=bresp[1], state IDLE.
REQ-024 READ: arvalid rises the cycle after accept, held until arready; then RD_RESP.
REQ-025 RD_RESP: rready=1 only here; on rvalid: rsp_rdata<=rdata, rsp_err=rresp[1], rsp_valid=1 next cycle, state IDLE.
REQ-026 valid never drops before handshake; addr/data/strb stable while valid; awprot=arprot=3'b000.
REQ-027 Zero-wait slave: accept cycle 0, handshake cycle 1, B/R cycle 2, rsp_valid and req_ready cycle 3; new request acceptable in cycle 3.
REQ-028 bvalid/rvalid outside WR_RESP/RD_RESP ignored (ready low); rsp_rdata unchanged by writes.

Reset
REQ-029 While areset: state IDLE, all AXI valids/readies 0, rsp_valid 0, rsp_err 0, rsp_rdata and latched addr/data/strb 0; mid-transaction reset abandons it immediately with no rsp_valid.

Structure
REQ-030 axi4_lite_pkg holds AXI resp enum (OKAY, EXOKAY, SLVERR, DECERR), FSM state typedef, default PROT constant; single module, no sub-module.

Verification
REQ-031 Write 0x0A4/0xDEADBEEF/strb 0xF, ready-high slave, bresp OKAY -> AW/W handshake cycle 1, rsp_valid cycle 3, rsp_err 0.
REQ-032 Write with wready 3 cycles after awready -> awvalid drops after cycle 1, wvalid held to cycle 4, single rsp_valid.
REQ-033 Read 0x010, rdata 0x12345678, rresp SLVERR -> rsp_rdata 0x12345678, rsp_err 1, one-cycle rsp_valid.
REQ-034 Back-to-back read after write with req_valid held -> second accepted in rsp_valid cycle, no overlap on AXI.
REQ-035 areset asserted while arvalid pending -> arvalid 0 immediately, no rsp_valid, req_ready 1 after release.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, adapter FSM encoding, default protection.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package axi4_lite_pkg;

    // AXI response codes as they appear on BRESP/RRESP
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    // Adapter FSM encoding, kept as plain constants so older tools can read it
    typedef logic [2:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE    = 3'd0;
    localparam fsm_state_t ST_WRITE   = 3'd1;
    localparam fsm_state_t ST_WR_RESP = 3'd2;
    localparam fsm_state_t ST_READ    = 3'd3;
    localparam fsm_state_t ST_RD_RESP = 3'd4;

    // Unprivileged, secure, data access
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // SLVERR and DECERR both report as an error to the local side
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi4_lite_master_adapter.sv
// Turns single local read/write requests into AXI4-Lite transactions, one outstanding at a time.
// Latency: zero-wait slave gives accept in cycle 0, rsp_valid (and req_ready again) in cycle 3.
// Backpressure: req_ready is low from accept until the completion cycle; AXI valids hold until handshake.
module axi4_lite_master_adapter
    import axi4_lite_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                        aclk,
    input  logic                        areset,

    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] req_wstrb,

    output logic                        rsp_valid,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic                        rsp_err,

    output logic [AXI_ADDR_WIDTH-1:0]   awaddr,
    output logic [2:0]                  awprot,
    output logic                        awvalid,
    input  logic                        awready,

    output logic [AXI_DATA_WIDTH-1:0]   wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] wstrb,
    output logic                        wvalid,
    input  logic                        wready,

    input  logic [1:0]                  bresp,
    input  logic                        bvalid,
    output logic                        bready,

    output logic [AXI_ADDR_WIDTH-1:0]   araddr,
    output logic [2:0]                  arprot,
    output logic                        arvalid,
    input  logic                        arready,

    input  logic [AXI_DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rvalid,
    output logic                        rready
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    fsm_state_t                r_state;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [AXI_DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]         r_wstrb;
    logic                      r_awvalid;
    logic                      r_wvalid;
    logic                      r_arvalid;
    logic                      r_rsp_valid;
    logic                      r_rsp_err;
    logic [AXI_DATA_WIDTH-1:0] r_rsp_rdata;

    logic w_accept;
    logic w_aw_fin;
    logic w_w_fin;
    logic w_b_hs;
    logic w_r_hs;

    // A channel counts as finished once its valid has dropped or it handshakes this cycle;
    // valid is only ever cleared by its own handshake, so a low valid inside WRITE means done.
    assign w_accept = req_valid && (r_state == ST_IDLE);
    assign w_aw_fin = !r_awvalid || awready;
    assign w_w_fin  = !r_wvalid  || wready;
    assign w_b_hs   = (r_state == ST_WR_RESP) && bvalid;
    assign w_r_hs   = (r_state == ST_RD_RESP) && rvalid;

    assign req_ready = (r_state == ST_IDLE);
    assign bready    = (r_state == ST_WR_RESP);
    assign rready    = (r_state == ST_RD_RESP);

    assign awaddr  = r_addr;
    assign awprot  = AXI_PROT_DEFAULT;
    assign awvalid = r_awvalid;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wvalid  = r_wvalid;
    assign araddr  = r_addr;
    assign arprot  = AXI_PROT_DEFAULT;
    assign arvalid = r_arvalid;

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

    // Capture the request payload on accept; it stays stable for the whole transaction
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
        end
    end

    // Transaction FSM and the AW/W/AR valids it owns
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state   <= ST_IDLE;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= req_write ? ST_WRITE : ST_READ;
                        r_awvalid <= req_write;
                        r_wvalid  <= req_write;
                        r_arvalid <= !req_write;
                    end
                end
                ST_WRITE: begin
                    if (r_awvalid && awready) r_awvalid <= 1'b0;
                    if (r_wvalid && wready)   r_wvalid  <= 1'b0;
                    if (w_aw_fin && w_w_fin)  r_state   <= ST_WR_RESP;
                end
                ST_WR_RESP: begin
                    if (bvalid) r_state <= ST_IDLE;
                end
                ST_READ: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (rvalid) r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b0;
                    r_arvalid <= 1'b0;
                end
            endcase
        end
    end

    // Completion pulse one cycle after the B/R handshake; rdata only moves on reads
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_b_hs || w_r_hs;
            if (w_b_hs) begin
                r_rsp_err <= resp_is_err(bresp);
            end else if (w_r_hs) begin
                r_rsp_err   <= resp_is_err(rresp);
                r_rsp_rdata <= rdata;
            end
        end
    end

endmodule
